// File: rtl/shacc_pipe.sv
// Shift-accumulator stage: realigns generator control with the returning MAC partial sum
// and folds bit-serial partial sums into a signed saturating accumulator.
module shacc_pipe #(
  parameter int BACC = 32,
  parameter int BDIN = 16,
  parameter int LAT  = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            en,
  input  logic            sh_in,
  input  logic            done_in,
  input  logic [BDIN-1:0] din,
  output logic [BACC-1:0] acc_out,
  output logic            acc_valid,
  output logic            ovf
);

  // Sum width covers the doubled accumulator plus a partial sum that may be wider than it.
  localparam int SW = (BACC + 2 > BDIN + 1) ? BACC + 2 : BDIN + 1;

  logic [LAT-1:0]  en_pipe;
  logic [LAT-1:0]  sh_pipe;
  logic [LAT-1:0]  done_pipe;
  logic            en_d;
  logic            sh_d;
  logic            done_d;

  logic [BACC-1:0] acc;
  logic [BACC:0]   shifted;
  logic [SW-1:0]   shifted_x;
  logic [SW-1:0]   din_x;
  logic [SW-1:0]   sum;
  logic            sat_pos;
  logic            sat_neg;
  logic [BACC-1:0] sat;

  assign en_d   = en_pipe[LAT-1];
  assign sh_d   = sh_pipe[LAT-1];
  assign done_d = done_pipe[LAT-1];

  assign shifted   = sh_d ? {acc, 1'b0} : {acc[BACC-1], acc};
  assign shifted_x = {{(SW-BACC-1){shifted[BACC]}}, shifted};
  assign din_x     = {{(SW-BDIN){din[BDIN-1]}}, din};
  assign sum       = shifted_x + din_x;

  // The value fits in BACC bits only when every bit from BACC-1 upward matches the sign.
  assign sat_pos = ~sum[SW-1] & (|sum[SW-2:BACC-1]);
  assign sat_neg =  sum[SW-1] & ~(&sum[SW-2:BACC-1]);

  always_comb begin
    sat = sum[BACC-1:0];
    if (sat_pos) begin
      sat = {1'b0, {(BACC-1){1'b1}}};
    end else if (sat_neg) begin
      sat = {1'b1, {(BACC-1){1'b0}}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_pipe   <= '0;
      sh_pipe   <= '0;
      done_pipe <= '0;
      acc       <= '0;
      acc_out   <= '0;
      acc_valid <= 1'b0;
      ovf       <= 1'b0;
    end else if (clr) begin
      en_pipe   <= '0;
      sh_pipe   <= '0;
      done_pipe <= '0;
      acc       <= '0;
      acc_out   <= '0;
      acc_valid <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      en_pipe[0]   <= en;
      sh_pipe[0]   <= sh_in & en;
      done_pipe[0] <= done_in & en;
      for (int i = 1; i < LAT; i++) begin
        en_pipe[i]   <= en_pipe[i-1];
        sh_pipe[i]   <= sh_pipe[i-1];
        done_pipe[i] <= done_pipe[i-1];
      end

      acc_valid <= 1'b0;
      if (en_d) begin
        if (sat_pos || sat_neg) begin
          ovf <= 1'b1;
        end
        if (done_d) begin
          acc_out   <= sat;
          acc_valid <= 1'b1;
          acc       <= '0;
        end else begin
          acc <= sat;
        end
      end
    end
  end

endmodule

// File: doc/shacc_pipe.md
# shacc_pipe

Shift-accumulator stage directly downstream of the input/weight address generator. It receives the generator's per-cycle control (`en`, `sh`, `done`) together with the MAC array's partial sum, which returns `LAT` cycles later after the memory read. It delays the control to line up with that data and folds the bit-serial partial sums into a signed saturating accumulator. On each accumulation-done event it presents the finished dot-product value to the output/quantizer stage as a one-cycle valid pulse.

## Interface
- `BACC`, 32: accumulator and output width, two's complement.
- `BDIN`, 16: partial-sum input width, two's complement.
- `LAT`, 2: cycles from the generator's `en` to the matching `din`. Legal range is 1..8.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `clr`  in  1  synchronous clear, active-high; same effect as reset.
- `en`  in  1  generator step, sampled in the generator's cycle t.
- `sh_in`  in  1  generator shift flag (`sh_out`); qualified by `en`.
- `done_in`  in  1  generator accumulation-done (`shacc_done`); already gated with `en` upstream.
- `din`  in  BDIN  signed MAC partial sum for the step issued at t; valid at t+LAT.
- `acc_out`  out  BACC  finished accumulation result.
- `acc_valid`  out  1  one-cycle pulse; `acc_out` is meaningful only while it is high.
- `ovf`  out  1  sticky saturation flag.

## Operation
- Control delay line: three LAT-deep shift registers carry `en`, `sh_in & en` and `done_in & en`. Their last stages are `en_d`, `sh_d` and `done_d`, which are aligned with `din`.
- Accumulator `acc` (BACC bits) updates only when `en_d`=1:
  - Compute `shifted = sh_d ? acc*2 : acc` at BACC+1 bits.
  - Compute `sum = shifted + sext(din)` at BACC+2 bits.
  - If `sum` > 2^(BACC-1)-1, clamp it to that value and set `ovf`.
  - If `sum` < -2^(BACC-1), clamp it to that value and set `ovf`.
- When `en_d`=0: `acc`, `acc_out` and `ovf` hold, and `din` is ignored.
- When `en_d`=1 and `done_d`=1:
  - The saturated `sum` is written to `acc_out`.
  - `acc_valid` is 1 in the next cycle.
  - `acc` is loaded with 0, so the next accumulation starts clean.
- No back-pressure. The consumer must take `acc_out` in the cycle `acc_valid` is high. `acc_out` holds its value until the next done.
- `ovf` is cleared only by reset or `clr`. It is not cleared by done.
- Reset or `clr` zeroes the delay line, `acc`, `acc_out`, `acc_valid` and `ovf`. All in-flight steps are discarded.

## Timing
- Reset values: `acc_out`=0, `acc_valid`=0, `ovf`=0. Internal `acc` and all delay stages are 0.
- Latency: done issued at generator cycle t gives `acc_valid`=1 in cycle t+LAT+1, with the final value on `acc_out`.
- Throughput: one step per cycle. Back-to-back done events, one every cycle, each produce their own pulse. A done immediately followed by a step starts the new accumulation from 0 in the same cycle.
- `clr` asserted together with any event, including `done_d`: `clr` wins. No `acc_valid` pulse is produced and all state is zeroed.
- `clr` mid-operation: steps issued before `clr` never affect state. A step issued in the cycle after `clr` is processed normally.
- `rst_n` deassertion is synchronised externally. Outputs change only on `clk` after release.
- `sh_d` on the first step after done or reset multiplies 0, so it has no effect.
- Gaps in `en` stretch the accumulation but do not alter the result.

## Test plan
- Basic bit-serial sum, BACC=32, LAT=2:
  - Stimulus: steps with (`din`, `sh`, `done`) = (3,0,0), (5,1,0), (2,1,1).
  - Response: `acc_valid` exactly 3 cycles after the done step, `acc_out`=24, `ovf`=0.
- Negative values and gaps:
  - Stimulus: steps (-4,0,0), idle 2 cycles, (1,1,0), idle 1 cycle, (-1,1,1).
  - Response: `acc_out`=-15, with the pulse LAT+1 cycles after the done step.
- Back-to-back done:
  - Stimulus: four consecutive steps with `done`=1 and `din`=7, -7, 100, 0.
  - Response: four consecutive pulses with `acc_out`=7, -7, 100, 0.
- Saturation, BACC=8:
  - Stimulus: steps (100,0,0), (60,1,1), then (-128,0,0), (-1,0,1).
  - Response: `acc_out`=127 then `acc_out`=-128.
  - `ovf` rises with the first saturating update and stays 1 until `clr`.
- `clr` mid-flight:
  - Stimulus: issue (9,0,1) and assert `clr` at t+1, so the step is still in the delay line.
  - Response: no pulse; `acc_out`=0.
  - The next step (4,0,1) yields `acc_out`=4.
- Async reset:
  - Stimulus: drop `rst_n` between clock edges while `acc_valid`=1.
  - Response: `acc_valid`, `acc_out` and `ovf` are 0 immediately, without waiting for an edge, and stay 0 until steps resume.
